// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uarttx transmitter between NUM_REQ requesters
// Define UART_ARB_TIMEOUT_EN to abort a WAIT that sees no donetx rise within TIMEOUT_CYCLES.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int CLK_FREQ       = 1000000,
   parameter int BAUD_RATE      = 9600,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] din,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   cmpl,
   output logic                 busy,
   output logic                 err,
   output logic                 send,
   output logic [7:0]           dintx,
   input  logic                 donetx
);
   localparam int CLKCOUNT = CLK_FREQ / BAUD_RATE;
   // One full period of the transmitter's divided clock, so its FSM cannot miss send.
   localparam int HOLD     = 2 * (CLKCOUNT / 2 + 1);
   localparam int PTR_W    = $clog2(NUM_REQ);
   localparam int HOLD_W   = $clog2(HOLD + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t             state, state_n;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
   logic [PTR_W-1:0]   gsel, gsel_n;
   logic [PTR_W-1:0]   pick, cand;
   logic               found;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
   logic               donetx_q;
   logic               rise;
   logic [NUM_REQ-1:0] ack_n, cmpl_n;
   logic               send_n;
   logic [7:0]         dintx_n;

   assign rise = donetx & ~donetx_q;

   // First requester strictly after the last winner, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt, to_cnt_n;
   logic            timeout;
   logic            err_n;

   assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign to_cnt_n = (state == WAIT && state_n == WAIT) ? to_cnt + 1'b1 : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         to_cnt <= to_cnt_n;
         err    <= err_n;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_n    = state;
      rr_ptr_n   = rr_ptr;
      gsel_n     = gsel;
      hold_cnt_n = hold_cnt;
      ack_n      = '0;
      cmpl_n     = '0;
      send_n     = send;
      dintx_n    = dintx;
`ifdef UART_ARB_TIMEOUT_EN
      err_n      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               gsel_n      = pick;
               rr_ptr_n    = pick;
               dintx_n     = din[8*pick +: 8];
               ack_n[pick] = 1'b1;
               send_n      = 1'b1;
               hold_cnt_n  = '0;
               state_n     = SEND;
            end
         end
         SEND: begin
            if (hold_cnt == HOLD_W'(HOLD - 1)) begin
               send_n     = 1'b0;
               hold_cnt_n = '0;
               state_n    = WAIT;
            end else begin
               hold_cnt_n = hold_cnt + 1'b1;
            end
         end
         WAIT: begin
            if (rise) begin
               cmpl_n[gsel] = 1'b1;
               state_n      = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (timeout) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= PTR_W'(NUM_REQ - 1);
         gsel     <= '0;
         hold_cnt <= '0;
         donetx_q <= 1'b0;
         ack      <= '0;
         cmpl     <= '0;
         busy     <= 1'b0;
         send     <= 1'b0;
         dintx    <= 8'h00;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         gsel     <= gsel_n;
         hold_cnt <= hold_cnt_n;
         donetx_q <= donetx;
         ack      <= ack_n;
         cmpl     <= cmpl_n;
         busy     <= (state_n != IDLE);
         send     <= send_n;
         dintx    <= dintx_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;
   localparam int NUM_REQ        = 4;
   localparam int CLK_FREQ       = 1000000;
   localparam int BAUD_RATE      = 9600;
   localparam int TIMEOUT_CYCLES = 200;
   localparam int HOLD           = 2 * ((CLK_FREQ / BAUD_RATE) / 2 + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] din;
   logic [NUM_REQ-1:0]   ack;
   logic [NUM_REQ-1:0]   cmpl;
   logic                 busy;
   logic                 err;
   logic                 send;
   logic [7:0]           dintx;
   logic                 donetx;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .cmpl(cmpl),
      .busy(busy), .err(err), .send(send), .dintx(dintx), .donetx(donetx)
   );

   typedef struct {
      int         kind;
      int         idx;
      logic [7:0] data;
   } ev_t;

   ev_t                sb[$];
   int                 vectors = 0;
   int                 miscompares = 0;
   logic [NUM_REQ-1:0] pend;
   logic [NUM_REQ-1:0] pulse;
   logic [7:0]         bytes [NUM_REQ];
   int                 rr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] p);
      for (int k = 1; k <= NUM_REQ; k++)
         if (p[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   // Expected {ack, cmpl, err} for one scoreboard event.
   function automatic logic [2*NUM_REQ:0] ev_vec(input ev_t e);
      logic [2*NUM_REQ:0] v;
      v = '0;
      if (e.kind == 0) v[NUM_REQ + 1 + e.idx] = 1'b1;
      else if (e.kind == 1) v[1 + e.idx] = 1'b1;
      else v[0] = 1'b1;
      return v;
   endfunction

   task automatic push_ev(input int kind, input int idx, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.idx  = idx;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic drive();
      req = pend | pulse;
      for (int i = 0; i < NUM_REQ; i++) din[8*i +: 8] = bytes[i];
   endtask

   // mode 0: normal frame, 1: reset 50 cycles into SEND, 2: donetx never rises (timeout)
   task automatic txn(input int mode, input bit rnd);
      int w, k, d, wj;
      w = rr_pick(rr, pend);
      if (w < 0) return;
      drive();
      push_ev(0, w, bytes[w]);
      if (mode == 0) push_ev(1, w, bytes[w]);
      else if (mode == 2) push_ev(2, w, bytes[w]);
      rr = w;
      @(negedge clk);
      check("ack_latency", ack[w], 1);
      if (rnd && $urandom_range(1) == 0) begin
         pend[w] = 1'b0;
         drive();
      end
      for (int c = 1; c < 90; c++) begin
         @(negedge clk);
         if (mode == 1 && c == 49) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_send", send, 0);
            pend = '0;
            drive();
            rr = NUM_REQ - 1;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (rnd && c == 10) begin
            wj = $urandom_range(NUM_REQ - 1);
            if (wj != w && $urandom_range(2) == 0) begin
               pend[wj] = 1'b0;
               drive();
            end
         end
         if (rnd && c == 20) begin
            wj = $urandom_range(NUM_REQ - 1);
            if (!pend[wj]) begin
               pulse[wj] = 1'b1;
               drive();
            end
         end
         if (c == 21) begin
            pulse = '0;
            drive();
         end
         if (c == 40 && $urandom_range(1) == 0) donetx = 1'b1;
         if (c == 43) donetx = 1'b0;
      end
      for (k = 0; k < 40 && send; k++) @(negedge clk);
      check("send_fall", send, 0);
      if (mode == 2) begin
         for (k = 1; k <= TIMEOUT_CYCLES; k++) begin
            @(negedge clk);
            if (k == TIMEOUT_CYCLES - 1) begin
               check("err_early", err, 0);
               check("busy_in_wait", busy, 1);
            end
         end
         check("err_pulse", err, 1);
         check("busy_after_abort", busy, 0);
         check("cmpl_after_abort", cmpl, 0);
         return;
      end
      d = $urandom_range(15);
      repeat (d) @(negedge clk);
      donetx = 1'b1;
      for (k = 0; k < 10 && cmpl == 0; k++) @(negedge clk);
      check("cmpl_latency", k, 1);
      donetx = 1'b0;
   endtask

   initial begin : monitor
      ev_t                e;
      int                 send_len;
      logic               send_prev;
      logic [2*NUM_REQ:0] act;
      send_len  = 0;
      send_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            send_len  = 0;
            send_prev = 1'b0;
         end else begin
            act = {ack, cmpl, err};
            if (act != 0) begin
               if (sb.size() == 0) begin
                  check("unexpected_event", act, 0);
               end else begin
                  e = sb.pop_front();
                  check("event", act, ev_vec(e));
                  if (e.kind != 2) check("dintx", dintx, e.data);
                  if (e.kind == 0) check("busy_at_ack", busy, 1);
               end
            end
            if (send && !send_prev) check("send_rise_with_ack", (ack != 0), 1);
            if (send) send_len++;
            if (!send && send_prev) begin
               check("send_hold", send_len, HOLD);
               send_len = 0;
            end
            send_prev = send;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench did not finish, %0d expected events outstanding", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      rst    = 1'b1;
      req    = '0;
      din    = '0;
      donetx = 1'b0;
      pend   = '0;
      pulse  = '0;
      rr     = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_cmpl", cmpl, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_send", send, 0);
      check("rst_dintx", dintx, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      bytes[0] = 8'hA5;
      pend = 4'b0001;
      txn(0, 0);
      pend = '0;
      drive();
      repeat (3) @(negedge clk);

      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      pend = 4'b1111;
      repeat (5) txn(0, 0);
      pend = '0;
      drive();
      repeat (3) @(negedge clk);

      repeat (40) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(1) == 1) begin
               pend[i]  = 1'b1;
               bytes[i] = 8'($urandom);
            end
         end
         if (pend == 0) begin
            pend[1]  = 1'b1;
            bytes[1] = 8'($urandom);
         end
         txn(0, 1);
      end
      pend = '0;
      drive();
      repeat (3) @(negedge clk);

      pend = 4'b1000;
      txn(0, 0);
      pend = 4'b1001;
      txn(0, 0);
      txn(0, 0);
      pend = '0;
      drive();
      repeat (3) @(negedge clk);

      bytes[0] = 8'h5A;
      pend = 4'b0001;
      txn(1, 0);
      repeat (5) @(negedge clk);
      pend = 4'b1001;
      txn(0, 0);
      pend = '0;
      drive();

`ifdef UART_ARB_TIMEOUT_EN
      repeat (3) @(negedge clk);
      bytes[2] = 8'hC3;
      pend = 4'b0100;
      txn(2, 0);
      pend = '0;
      drive();
`endif

      repeat (20) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
